// File: rtl/req_encoder_pkg.sv
// Shared constants and helpers for the request encoder (selection modes, index width).
package req_encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_pick.sv
// Combinational selector: lowest set index (fixed) or first set index after ptr (round-robin).
module req_pick
  import req_encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  localparam int W   = idx_w(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  int           sh;
  int           pos;

  always_comb begin
    sh = 0;
    if (MODE == MODE_RR) sh = (int'(ptr) + 1) % N;
    // Rotate so the search origin lands on bit 0, encode, then rotate the index back.
    rot = (cand >> sh) | (cand << (N - sh));
    pos = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    idx = W'((pos + sh) % N);
    any = |cand;
  end

endmodule

// File: rtl/req_encoder.sv
// Registered multi-request encoder with valid/ready output slot.
// Build option: REQ_ENCODER_BYPASS_EN lets a request arriving on a free slot issue one edge earlier.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  localparam int W   = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] in,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending
);

  logic [N-1:0] pending_p0;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] keep_vec;
  logic [N-1:0] cand;
  logic [N-1:0] onehot;
  logic [W-1:0] out_p1;
  logic [W-1:0] ptr_p1;
  logic [W-1:0] pick_idx;
  logic         vld_p1;
  logic         pick_any;
  logic         load;

  always_comb begin
    set_vec = enable ? in : '0;
`ifdef REQ_ENCODER_BYPASS_EN
    cand = pending_p0 | set_vec;
`else
    cand = pending_p0;
`endif
    load    = !vld_p1 || out_ready;
    onehot  = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    clr_vec = (load && pick_any) ? onehot : '0;
`ifdef REQ_ENCODER_BYPASS_EN
    // A bit issued straight from the input is consumed, not also parked in pending.
    keep_vec = set_vec & ~(clr_vec & ~pending_p0);
`else
    keep_vec = set_vec;
`endif
  end

  req_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .cand (cand),
    .ptr  (ptr_p1),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // p0: pending capture / p1: issued slot and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_p0 <= '0;
      out_p1     <= '0;
      vld_p1     <= 1'b0;
      ptr_p1     <= W'(N - 1);
    end else begin
      pending_p0 <= (pending_p0 & ~clr_vec) | keep_vec;
      if (load) begin
        vld_p1 <= pick_any;
        if (pick_any) begin
          out_p1 <= pick_idx;
          ptr_p1 <= pick_idx;
        end
      end
    end
  end

  assign out       = out_p1;
  assign out_valid = vld_p1;
  assign pending   = pending_p0;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder: a fixed-priority and a round-robin instance share stimulus.
module tb_req_encoder;

`ifdef REQ_ENCODER_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] out0, out1;
  logic       vld0, vld1;
  logic [7:0] pend0, pend1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic       exp_vld;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t vecs[20];

  req_encoder #(.N(8), .MODE(0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(req),
    .out(out0), .out_valid(vld0), .out_ready(out_ready), .pending(pend0)
  );

  req_encoder #(.N(8), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(req),
    .out(out1), .out_valid(vld1), .out_ready(out_ready), .pending(pend1)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    enable    = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_seq[6];
    int guard;
    rr_seq = '{0, 1, 7, 0, 1, 7};

    for (int i = 0; i < 8; i++) begin
      vecs[2*i]   = '{1'b0, 8'(1 << i), 1'b0, 3'd0};
      vecs[2*i+1] = '{1'b1, 8'(1 << i), 1'b1, 3'(i)};
    end
    vecs[16] = '{1'b1, 8'hF0, 1'b1, 3'd4};
    vecs[17] = '{1'b1, 8'h81, 1'b1, 3'd0};
    vecs[18] = '{1'b1, 8'h06, 1'b1, 3'd1};
    vecs[19] = '{1'b1, 8'h80, 1'b1, 3'd7};

    // Reset and idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      check("idle_fixed", {vld0, 5'd0, out0, pend0}, 32'h0);
      check("idle_rr", {vld1, 5'd0, out1, pend1}, 32'h0);
      step();
    end

    // Fixed-priority drain of a multi-hot pulse
    do_reset();
    req = 8'b1010_0100;
    step();
    req = '0;
`ifdef REQ_ENCODER_BYPASS_EN
    check("drain_pend", pend0, 8'hA0);
`else
    check("drain_pend", pend0, 8'hA4);
`endif
    repeat (LAT - 1) step();
    check("drain_v0", vld0, 1); check("drain_o0", out0, 2); step();
    check("drain_v1", vld0, 1); check("drain_o1", out0, 5); step();
    check("drain_v2", vld0, 1); check("drain_o2", out0, 7); step();
    check("drain_end", {vld0, pend0}, 9'h0);

    // Table: enable gating sweep plus multi-hot first picks
    do_reset();
    for (int v = 0; v < 20; v++) begin
      enable = vecs[v].en;
      req    = vecs[v].req;
      step();
      req    = '0;
      enable = 1'b1;
      if (!vecs[v].en) check("vec_gated_pend", pend0, 8'h00);
      repeat (LAT - 1) step();
      check("vec_vld", vld0, vecs[v].exp_vld);
      if (vecs[v].exp_vld) check("vec_idx", out0, vecs[v].exp_idx);
      guard = 0;
      while (vld0 && guard < 12) begin
        step();
        guard++;
      end
      check("vec_idle", {vld0, pend0}, 9'h0);
    end

    // Round-robin fairness vs fixed priority under a held request
    do_reset();
    req = 8'b1000_0011;
    step();
    repeat (LAT - 1) step();
    for (int c = 0; c < 6; c++) begin
      check("rr_vld", vld1, 1);
      check("rr_seq", out1, rr_seq[c]);
      check("fixed_held", {vld0, 5'd0, out0}, 32'h100);
      step();
    end
    req = '0;

    // All-ones drain: both modes issue 0..7 back to back
    do_reset();
    req = 8'hFF;
    step();
    req = '0;
    repeat (LAT - 1) step();
    for (int c = 0; c < 8; c++) begin
      check("ones_fixed", {vld0, 5'd0, out0}, 32'h100 | c);
      check("ones_rr", {vld1, 5'd0, out1}, 32'h100 | c);
      step();
    end
    check("ones_end", {vld0, vld1}, 2'b00);

    // Backpressure: out holds while new requests accumulate
    do_reset();
    out_ready = 1'b0;
    req = 8'h08;
    step();
    req = '0;
    repeat (LAT - 1) step();
    check("bp_first", {vld0, 5'd0, out0}, 32'h103);
    for (int c = 0; c < 5; c++) begin
      req = (c == 0) ? 8'h02 : (c == 2) ? 8'h40 : 8'h00;
      step();
      check("bp_hold", {vld0, 5'd0, out0}, 32'h103);
    end
    req = '0;
    check("bp_pend", pend0, 8'b0100_0010);
    out_ready = 1'b1;
    step();
    check("bp_rel1", {vld0, 5'd0, out0}, 32'h101);
    step();
    check("bp_rel2", {vld0, 5'd0, out0}, 32'h106);
    step();
    check("bp_end", {vld0, pend0}, 9'h0);

    // Same-cycle set and clear on bit 4
    do_reset();
    req = 8'h10;
    step();
`ifdef REQ_ENCODER_BYPASS_EN
    check("sc_issue1", {vld0, 5'd0, out0}, 32'h104);
    check("sc_pend1", pend0, 8'h00);
    step();
    req = '0;
    check("sc_issue2", {vld0, 5'd0, out0}, 32'h104);
    check("sc_pend2", pend0, 8'h00);
`else
    step();
    req = '0;
    check("sc_issue1", {vld0, 5'd0, out0}, 32'h104);
    check("sc_pend1", pend0, 8'h10);
    step();
    check("sc_issue2", {vld0, 5'd0, out0}, 32'h104);
    check("sc_pend2", pend0, 8'h00);
`endif
    step();
    check("sc_end", vld0, 0);

    // Asynchronous reset mid-drain drops the in-flight index
    req = 8'hFF;
    step();
    req = '0;
    repeat (LAT - 1) step();
    check("mid_o0", out0, 0);
    step();
    check("mid_o1", out0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_fixed", {vld0, 5'd0, out0, pend0}, 32'h0);
    check("async_rr", {vld1, pend1}, 9'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst", {vld0, vld1, pend0}, 10'h0);
    end

`ifdef REQ_ENCODER_BYPASS_EN
    // Bypass: single pulse on an idle block issues one edge later
    do_reset();
    req = 8'b0001_0000;
    step();
    req = '0;
    check("bypass_lat", {vld0, 5'd0, out0}, 32'h104);
    check("bypass_pend", pend0, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
